// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchronises each input, debounces it against a
// shared threshold, and reports rising/falling edges as pulses and sticky pending flags.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   signal,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [DEB_W-1:0]   deb_len,
  input  logic [WIDTH-1:0]   clear,
  output logic [WIDTH-1:0]   posedge_detected,
  output logic [WIDTH-1:0]   negedge_detected,
  output logic [WIDTH-1:0]   pending,
  output logic               irq
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [DEB_W-1:0] cnt     [WIDTH];
  logic [DEB_W-1:0] cnt_nxt [WIDTH];

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= signal;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  // The counter measures how long sync_q has disagreed with stable; once it
  // reaches deb_len the disagreement is accepted and the edge is reported.
  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    fall       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q[i] != stable[i]) begin
        if (cnt[i] >= deb_len) begin
          stable_nxt[i] = sync_q[i];
          rise[i]       = sync_q[i] & mode[2*i];
          fall[i]       = ~sync_q[i] & mode[2*i+1];
        end else if (cnt[i] != '1) begin
          cnt_nxt[i] = cnt[i] + DEB_W'(1);
        end else begin
          cnt_nxt[i] = cnt[i];
        end
      end
    end
  end

  // A pulse setting pending takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable           <= '0;
      posedge_detected <= '0;
      negedge_detected <= '0;
      pending          <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable           <= stable_nxt;
      posedge_detected <= rise;
      negedge_detected <= fall;
      pending          <= (pending & ~clear) | rise | fall;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: a sample-history model checked every cycle,
// plus directed scenarios with literal expectations at the key edges.
module tb_multi_edge_detector;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_W       = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   signal;
  logic [2*WIDTH-1:0] mode;
  logic [DEB_W-1:0]   deb_len;
  logic [WIDTH-1:0]   clear;
  logic [WIDTH-1:0]   posedge_detected;
  logic [WIDTH-1:0]   negedge_detected;
  logic [WIDTH-1:0]   pending;
  logic               irq;

  int nCompared   = 0;
  int nMismatched = 0;

  multi_edge_detector #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W)
  ) dut (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .deb_len(deb_len),
    .clear(clear), .posedge_detected(posedge_detected),
    .negedge_detected(negedge_detected), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: sync_q seen at an edge is the input sampled SYNC_STAGES edges
  // earlier; the filtered level flips once sync_q has disagreed with it on
  // more than deb_len consecutive edges.
  logic [WIDTH-1:0] window[$];
  logic [WIDTH-1:0] mStable, mPos, mNeg, mPend;
  int               mRun [WIDTH];

  initial begin
    logic [WIDTH-1:0] seen;
    window = {};
    for (int s = 0; s < SYNC_STAGES; s++) window.push_front('0);
    mStable = '0; mPos = '0; mNeg = '0; mPend = '0;
    for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        window = {};
        for (int s = 0; s < SYNC_STAGES; s++) window.push_front('0);
        mStable = '0; mPos = '0; mNeg = '0; mPend = '0;
        for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
      end else begin
        seen = window.pop_back();
        window.push_front(signal);
        mPend = mPend & ~clear;
        mPos  = '0;
        mNeg  = '0;
        for (int i = 0; i < WIDTH; i++) begin
          mRun[i] = (seen[i] != mStable[i]) ? mRun[i] + 1 : 0;
          if (mRun[i] > int'(deb_len)) begin
            mStable[i] = seen[i];
            mRun[i]    = 0;
            if (seen[i] && mode[2*i])    mPos[i] = 1'b1;
            if (!seen[i] && mode[2*i+1]) mNeg[i] = 1'b1;
          end
        end
        mPend = mPend | mPos | mNeg;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_pos",  32'(posedge_detected), 32'(mPos));
      checkOutput("model_neg",  32'(negedge_detected), 32'(mNeg));
      checkOutput("model_pend", 32'(pending),          32'(mPend));
      checkOutput("model_irq",  32'(irq),              32'(|mPend));
    end
  end

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; signal = '0; mode = '0; deb_len = '0; clear = '0;
    applyStimulus(2);
    checkOutput("reset_pos",  32'(posedge_detected), 32'h0);
    checkOutput("reset_pend", 32'(pending),          32'h0);
    checkOutput("reset_irq",  32'(irq),              32'h0);
    reset = 1'b0;
    applyStimulus(2);

    // Channel 0 rise with no debounce
    mode = 16'h0001; signal[0] = 1'b1;
    applyStimulus(3);
    checkOutput("ch0_pos",      32'(posedge_detected), 32'h01);
    checkOutput("ch0_pend",     32'(pending),          32'h01);
    checkOutput("ch0_irq",      32'(irq),              32'h1);
    applyStimulus(1);
    checkOutput("ch0_pos_gone", 32'(posedge_detected), 32'h00);
    clear = 8'h01;
    applyStimulus(1);
    clear = '0;
    checkOutput("ch0_cleared",  32'(pending),          32'h00);

    // Channel 1 debounce: short glitch rejected, longer pulse accepted
    deb_len = 4'd3; mode = 16'h0004;
    signal[1] = 1'b1;
    applyStimulus(3);
    signal[1] = 1'b0;
    applyStimulus(10);
    checkOutput("ch1_glitch_pend", 32'(pending), 32'h00);
    signal[1] = 1'b1;
    applyStimulus(4);
    signal[1] = 1'b0;
    applyStimulus(2);
    checkOutput("ch1_pos",      32'(posedge_detected), 32'h02);
    applyStimulus(1);
    checkOutput("ch1_pos_gone", 32'(posedge_detected), 32'h00);
    applyStimulus(10);
    clear = 8'h02;
    applyStimulus(1);
    clear = '0;

    // Channel 2 both-edge mode, then mode off
    deb_len = '0; mode = '0; signal[2] = 1'b1;
    applyStimulus(6);
    mode = 16'h0030; signal[2] = 1'b0;
    applyStimulus(3);
    checkOutput("ch2_neg",      32'(negedge_detected), 32'h04);
    checkOutput("ch2_no_pos",   32'(posedge_detected), 32'h00);
    applyStimulus(1);
    checkOutput("ch2_neg_gone", 32'(negedge_detected), 32'h00);
    applyStimulus(9);
    signal[2] = 1'b1;
    applyStimulus(3);
    checkOutput("ch2_pos",      32'(posedge_detected), 32'h04);
    applyStimulus(7);
    clear = 8'hFF;
    applyStimulus(1);
    clear = '0;
    mode = '0; signal[2] = 1'b0;
    applyStimulus(10);
    signal[2] = 1'b1;
    applyStimulus(10);
    checkOutput("ch2_off_pend", 32'(pending), 32'h00);

    // Channel 3 clear coinciding with the pulse, then on the next cycle
    mode = 16'h0040; signal[3] = 1'b1;
    applyStimulus(2);
    clear = 8'h08;
    applyStimulus(1);
    checkOutput("ch3_pos",         32'(posedge_detected), 32'h08);
    checkOutput("ch3_set_wins",    32'(pending),          32'h08);
    applyStimulus(1);
    checkOutput("ch3_cleared",     32'(pending),          32'h00);
    checkOutput("ch3_irq_cleared", 32'(irq),              32'h0);
    clear = '0;

    // All channels rise together
    mode = '0; signal = '0;
    applyStimulus(6);
    mode = 16'h5555; signal = 8'hFF;
    applyStimulus(3);
    checkOutput("all_pos",      32'(posedge_detected), 32'hFF);
    checkOutput("all_pend",     32'(pending),          32'hFF);
    applyStimulus(1);
    checkOutput("all_pos_gone", 32'(posedge_detected), 32'h00);

    // Asynchronous reset in the middle of a debounce count
    signal = '0;
    applyStimulus(6);
    deb_len = 4'd5; signal = 8'h01;
    applyStimulus(4);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_pos",  32'(posedge_detected), 32'h00);
    checkOutput("async_rst_pend", 32'(pending),          32'h00);
    checkOutput("async_rst_irq",  32'(irq),              32'h0);
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(7);
    checkOutput("post_rst_early", 32'(posedge_detected), 32'h00);
    applyStimulus(1);
    checkOutput("post_rst_pos",   32'(posedge_detected), 32'h01);
    applyStimulus(1);
    checkOutput("post_rst_gone",  32'(posedge_detected), 32'h00);
    checkOutput("post_rst_pend",  32'(pending),          32'h01);

    applyStimulus(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
